gpio_ctrl: RTL and testbench

Parametrised, memory-mapped GPIO controller. It is the next generation of the single-bank GPIO register block, and sits on the same simple en/wr/addr_offset register bus.
- Adds configurable pin count.
- Adds a synchronised pin input.
- Adds atomic set/clear/toggle writes.
- Adds per-pin edge interrupts with a write-1-to-clear status register.
- Drives pad output data and output-enable directly.

---
 rtl/gpio_pkg.sv | 16 +
 rtl/gpio_sync_edge.sv | 34 +++
 rtl/gpio_ctrl.sv | 106 ++++++++++
 tb/tb_gpio_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_pkg.sv
// Shared register offsets and limits for the GPIO controller.
package gpio_pkg;

  localparam logic [7:0] GPIO_DATA     = 8'h00;
  localparam logic [7:0] GPIO_DIR      = 8'h04;
  localparam logic [7:0] GPIO_PIN      = 8'h08;
  localparam logic [7:0] GPIO_SET      = 8'h0C;
  localparam logic [7:0] GPIO_CLR      = 8'h10;
  localparam logic [7:0] GPIO_TGL      = 8'h14;
  localparam logic [7:0] GPIO_IRQ_EN   = 8'h18;
  localparam logic [7:0] GPIO_IRQ_POL  = 8'h1C;
  localparam logic [7:0] GPIO_IRQ_STAT = 8'h20;

  localparam int GPIO_MAX_WIDTH = 32;

endpackage

// File: rtl/gpio_sync_edge.sv
// Pad input synchroniser followed by a one-flop history used to detect
// rising and falling edges on the synchronised value.
module gpio_sync_edge #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_in,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] prev_q;

  // Stage 0 may go metastable; only the last stage is consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) sync_q[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign sync_in = sync_q[STAGES-1];
  assign rise    = sync_in & ~prev_q;
  assign fall    = ~sync_in & prev_q;

endmodule

// File: rtl/gpio_ctrl.sv
// Memory-mapped GPIO bank: data/direction registers, atomic set/clear/toggle
// writes, synchronised pin readback and per-pin edge interrupts.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int GPIO_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  wr,
  input  logic [7:0]            addr_offset,
  input  logic [31:0]           data_in,
  output logic [31:0]           data_out,
  output logic                  rd_valid,
  input  logic [GPIO_WIDTH-1:0] gpio_in,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic [GPIO_WIDTH-1:0] gpio_oe,
  output logic                  irq
);

  localparam int W = GPIO_WIDTH;

  logic [W-1:0] data_q, dir_q, irq_en_q, irq_pol_q, irq_stat_q;
  logic [W-1:0] sync_in, rise, fall, evt, wdata, w1c_mask;
  logic [31:0]  rd_data;
  logic         wr_strobe, rd_strobe;

  assign wr_strobe = en & wr;
  assign rd_strobe = en & ~wr;
  assign wdata     = data_in[W-1:0];

  gpio_sync_edge #(
    .WIDTH  (W),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst      (rst),
    .async_in (gpio_in),
    .sync_in  (sync_in),
    .rise     (rise),
    .fall     (fall)
  );

  assign evt      = irq_en_q & ((irq_pol_q & rise) | (~irq_pol_q & fall));
  assign w1c_mask = (wr_strobe && addr_offset == GPIO_IRQ_STAT) ? wdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      dir_q     <= '0;
      irq_en_q  <= '0;
      irq_pol_q <= '0;
    end else if (wr_strobe) begin
      case (addr_offset)
        GPIO_DATA:    data_q    <= wdata;
        GPIO_DIR:     dir_q     <= wdata;
        GPIO_SET:     data_q    <= data_q | wdata;
        GPIO_CLR:     data_q    <= data_q & ~wdata;
        GPIO_TGL:     data_q    <= data_q ^ wdata;
        GPIO_IRQ_EN:  irq_en_q  <= wdata;
        GPIO_IRQ_POL: irq_pol_q <= wdata;
        default: ;
      endcase
    end
  end

  // A new event on a bit beats a simultaneous write-1-to-clear of that bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_stat_q <= '0;
      irq        <= 1'b0;
    end else begin
      irq_stat_q <= (irq_stat_q & ~w1c_mask) | evt;
      irq        <= |(irq_stat_q & irq_en_q);
    end
  end

  always_comb begin
    rd_data = '0;
    case (addr_offset)
      GPIO_DATA:     rd_data[W-1:0] = data_q;
      GPIO_DIR:      rd_data[W-1:0] = dir_q;
      GPIO_PIN:      rd_data[W-1:0] = (data_q & dir_q) | (sync_in & ~dir_q);
      GPIO_IRQ_EN:   rd_data[W-1:0] = irq_en_q;
      GPIO_IRQ_POL:  rd_data[W-1:0] = irq_pol_q;
      GPIO_IRQ_STAT: rd_data[W-1:0] = irq_stat_q;
      default:       rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_strobe;
      if (rd_strobe) data_out <= rd_data;
    end
  end

  assign gpio_out = data_q;
  assign gpio_oe  = dir_q;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Self-checking bench for gpio_ctrl (8 pins, 2 sync stages): directed
// scenarios plus randomized bus traffic against a cycle-level reference model.
module tb_gpio_ctrl;
  import gpio_pkg::*;

  localparam int WIDTH = 8;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, wr = 1'b0;
  logic [7:0]  addr_offset = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic        rd_valid;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out, gpio_oe;
  logic        irq;

  logic [7:0] pins = '0;

  int checkCount = 0;
  int failCount  = 0;

  // Reference model state: architectural registers plus a history of
  // pad samples taken at each rising clock edge (newest first).
  logic [7:0]  m_data, m_dir, m_en, m_pol, m_stat;
  logic        m_irq, m_rv;
  logic [31:0] m_dout;
  logic [7:0]  samp[$];

  gpio_ctrl #(.GPIO_WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr          (wr),
    .addr_offset (addr_offset),
    .data_in     (data_in),
    .data_out    (data_out),
    .rd_valid    (rd_valid),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .gpio_oe     (gpio_oe),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic resetModel();
    m_data = '0; m_dir = '0; m_en = '0; m_pol = '0; m_stat = '0;
    m_irq = 1'b0; m_rv = 1'b0; m_dout = '0;
    samp.delete();
    repeat (SYNC + 1) samp.push_back(8'h00);
  endtask

  // What one clock edge does, from the register map rules: events come from
  // the synchronised pin value seen SYNC edges late, read data reflects
  // pre-edge state, and irq reflects pre-edge status and enables.
  task automatic modelEdge(input logic e, input logic w, input logic [7:0] a,
                           input logic [31:0] d, input logic [7:0] p);
    logic [7:0] sync_v, prev_v, evt, mask, rv8;
    logic       nirq;
    sync_v = samp[SYNC-1];
    prev_v = samp[SYNC];
    evt    = m_en & ((m_pol & sync_v & ~prev_v) | (~m_pol & ~sync_v & prev_v));
    nirq   = (m_stat & m_en) != 8'h00;
    rv8    = 8'h00;
    if (e && !w) begin
      if      (a == 8'h00) rv8 = m_data;
      else if (a == 8'h04) rv8 = m_dir;
      else if (a == 8'h08) rv8 = (m_data & m_dir) | (sync_v & ~m_dir);
      else if (a == 8'h18) rv8 = m_en;
      else if (a == 8'h1C) rv8 = m_pol;
      else if (a == 8'h20) rv8 = m_stat;
      m_dout = {24'h0, rv8};
    end
    m_rv = e && !w;
    mask = 8'h00;
    if (e && w) begin
      if      (a == 8'h00) m_data = d[7:0];
      else if (a == 8'h04) m_dir  = d[7:0];
      else if (a == 8'h0C) m_data = m_data | d[7:0];
      else if (a == 8'h10) m_data = m_data & ~d[7:0];
      else if (a == 8'h14) m_data = m_data ^ d[7:0];
      else if (a == 8'h18) m_en   = d[7:0];
      else if (a == 8'h1C) m_pol  = d[7:0];
      else if (a == 8'h20) mask   = d[7:0];
    end
    m_stat = (m_stat & ~mask) | evt;
    m_irq  = nirq;
    samp.push_front(p);
    void'(samp.pop_back());
  endtask

  // Drive one bus cycle, let the edge happen, then compare all outputs.
  task automatic applyStimulus(input logic e, input logic w, input logic [7:0] a,
                               input logic [31:0] d);
    en = e; wr = w; addr_offset = a; data_in = d; gpio_in = pins;
    @(posedge clk);
    modelEdge(e, w, a, d, pins);
    #1;
    checkOutput("gpio_out", {24'h0, gpio_out}, {24'h0, m_data});
    checkOutput("gpio_oe",  {24'h0, gpio_oe},  {24'h0, m_dir});
    checkOutput("irq",      {31'h0, irq},      {31'h0, m_irq});
    checkOutput("rd_valid", {31'h0, rd_valid}, {31'h0, m_rv});
    checkOutput("data_out", data_out, m_dout);
    en = 1'b0; wr = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] a, input logic [31:0] d);
    applyStimulus(1'b1, 1'b1, a, d);
  endtask

  task automatic readReg(input logic [7:0] a);
    applyStimulus(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(1'b0, 1'b0, 8'h00, 32'h0);
  endtask

  logic [7:0] offs [10] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                            8'h14, 8'h18, 8'h1C, 8'h20, 8'h24};

  initial begin
    logic [7:0] ra;
    resetModel();
    #3;
    checkOutput("rst_irq", {31'h0, irq}, 32'h0);
    checkOutput("rst_gpio_out", {24'h0, gpio_out}, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    $display("[TB] reset values, read every offset");
    for (int i = 0; i < 10; i++) begin
      readReg(offs[i]);
      checkOutput("reset_read", data_out, 32'h0);
      checkOutput("reset_rd_valid", {31'h0, rd_valid}, 32'h1);
    end
    idle(1);
    checkOutput("rd_valid_drop", {31'h0, rd_valid}, 32'h0);

    $display("[TB] direction and pin readback");
    writeReg(GPIO_DIR, 32'h0F);
    writeReg(GPIO_DATA, 32'hA5);
    pins = 8'h30;
    idle(3);
    readReg(GPIO_PIN);
    checkOutput("pin_read", data_out, 32'h35);
    checkOutput("oe_value", {24'h0, gpio_oe}, 32'h0F);
    checkOutput("out_value", {24'h0, gpio_out}, 32'hA5);

    $display("[TB] atomic set/clear/toggle");
    writeReg(GPIO_SET, 32'h40);
    checkOutput("set", {24'h0, gpio_out}, 32'hE5);
    writeReg(GPIO_CLR, 32'h05);
    checkOutput("clr", {24'h0, gpio_out}, 32'hE0);
    writeReg(GPIO_TGL, 32'hFF);
    checkOutput("tgl", {24'h0, gpio_out}, 32'h1F);
    writeReg(GPIO_DATA, 32'hFFFFFF00);
    readReg(GPIO_DATA);
    checkOutput("upper_bits", data_out, 32'h0);

    $display("[TB] rising-edge interrupt on pin 0");
    writeReg(GPIO_IRQ_EN, 32'h01);
    writeReg(GPIO_IRQ_POL, 32'h01);
    pins = 8'h31;
    idle(3);
    checkOutput("irq_not_yet", {31'h0, irq}, 32'h0);
    readReg(GPIO_IRQ_STAT);
    checkOutput("stat_set", data_out, 32'h01);
    checkOutput("irq_rise", {31'h0, irq}, 32'h1);
    pins = 8'h30;
    idle(4);
    readReg(GPIO_IRQ_STAT);
    checkOutput("no_fall_evt", data_out, 32'h01);
    writeReg(GPIO_IRQ_STAT, 32'h01);
    checkOutput("irq_hold", {31'h0, irq}, 32'h1);
    idle(1);
    checkOutput("irq_cleared", {31'h0, irq}, 32'h0);

    $display("[TB] falling-edge event colliding with write-1-to-clear");
    writeReg(GPIO_IRQ_POL, 32'h00);
    writeReg(GPIO_IRQ_EN, 32'h08);
    pins = 8'h38; idle(4);
    pins = 8'h30; idle(4);
    checkOutput("fall_irq", {31'h0, irq}, 32'h1);
    pins = 8'h38; idle(4);
    pins = 8'h30;
    idle(2);
    writeReg(GPIO_IRQ_STAT, 32'h08);
    idle(1);
    checkOutput("collide_irq", {31'h0, irq}, 32'h1);
    readReg(GPIO_IRQ_STAT);
    checkOutput("collide_stat", data_out, 32'h08);

    $display("[TB] asynchronous reset mid-write");
    en = 1'b1; wr = 1'b1; addr_offset = GPIO_DATA; data_in = 32'h5A;
    #3 rst = 1'b1;
    #1;
    checkOutput("arst_irq", {31'h0, irq}, 32'h0);
    checkOutput("arst_gpio_out", {24'h0, gpio_out}, 32'h0);
    checkOutput("arst_gpio_oe", {24'h0, gpio_oe}, 32'h0);
    checkOutput("arst_data_out", data_out, 32'h0);
    checkOutput("arst_rd_valid", {31'h0, rd_valid}, 32'h0);
    en = 1'b0; wr = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    resetModel();
    pins = 8'h00;
    @(posedge clk);
    modelEdge(1'b0, 1'b0, 8'h00, 32'h0, pins);
    #1;
    readReg(GPIO_DATA);
    checkOutput("post_rst_data", data_out, 32'h0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) pins = 8'($urandom);
      ra = ($urandom_range(0, 15) == 0) ? 8'($urandom) : offs[$urandom_range(0, 9)];
      case ($urandom_range(0, 2))
        0: applyStimulus(1'b1, 1'b1, ra, $urandom);
        1: applyStimulus(1'b1, 1'b0, ra, $urandom);
        default: applyStimulus(1'b0, 1'($urandom), ra, $urandom);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
